// File: rtl/error_sum_accumulator.sv
// error_sum_accumulator: per-bit mismatch counters over a stream of samples for one chromosome evaluation
module error_sum_accumulator #(
  parameter int NUM_BITS  = 8,
  parameter int SUM_WIDTH = 32
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic                          iStart,
  input  logic                          iSampleValid,
  input  logic [NUM_BITS-1:0]           iChromOutput,
  input  logic [NUM_BITS-1:0]           iExpectedOutput,
  input  logic [NUM_BITS-1:0]           iValidOutput,
  input  logic                          iLastSample,
  input  logic                          iDoneAck,
  output logic                          oReady,
  output logic                          oDone,
  output logic [NUM_BITS*SUM_WIDTH-1:0] oErrorSums,
  output logic [15:0]                   oSampleCount
);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
  state_t                state_q, state_d;
  logic [NUM_BITS-1:0]   mis_q;
  logic                  s1_valid_q;
  logic [15:0]           count_q;
  logic [SUM_WIDTH-1:0]  sum_q [NUM_BITS];
  logic                  start, accept;
  assign start  = (state_q == IDLE) && iStart;
  assign accept = (state_q == ACCUM) && iSampleValid;
  // FLUSH holds until the last sample's stage-2 update has landed
  always_comb
    state_d = start                                  ? ACCUM :
              (accept && iLastSample)                ? FLUSH :
              (state_q == FLUSH && !s1_valid_q)      ? DONE  :
              (state_q == DONE && iDoneAck)          ? IDLE  : state_q;
  always_ff @(posedge iClock or posedge iReset)
    if (iReset) begin
      state_q    <= IDLE;
      mis_q      <= '0;
      s1_valid_q <= 1'b0;
      count_q    <= '0;
      for (int k = 0; k < NUM_BITS; k++) sum_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      mis_q      <= accept ? (iChromOutput ^ iExpectedOutput) & iValidOutput : '0;
      if (start) count_q <= '0;
      else if (accept && count_q != '1) count_q <= count_q + 16'd1;
      for (int k = 0; k < NUM_BITS; k++)
        if (start) sum_q[k] <= '0;
        else if (s1_valid_q && mis_q[k] && sum_q[k] != '1) sum_q[k] <= sum_q[k] + 1'b1;
    end
  for (genvar k = 0; k < NUM_BITS; k++) begin : g_out
    assign oErrorSums[k*SUM_WIDTH +: SUM_WIDTH] = sum_q[k];
  end
  assign oReady       = state_q == IDLE;
  assign oDone        = state_q == DONE;
  assign oSampleCount = count_q;
endmodule
